sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
Parametrised successor to the single write/read channel SDRAM FIFO front end. It arbitrates NUM_PORTS independent write channels and NUM_PORTS independent read channels onto the one request/ack pair of the SDRAM core. Each channel has its own burst length, start/max address, load and done state, and its own wrap or one-shot mode. It sits between the per-channel dual-clock FIFO controllers and the SDRAM core, entirely in the SDRAM reference clock domain.

Parameters:
NUM_PORTS, 2, number of write channels, equal to the number of read channels (1..4)
ADDR_W, 22, SDRAM word address width
LEN_W, 9, burst length width in words
WR_WRAP, all ones, NUM_PORTS-bit mask; bit p=1: write channel p wraps to its start address; bit p=0: one-shot, stops and sets done
RD_WRAP, all ones, same as WR_WRAP for read channels

Ports:
clk_ref  in  1  SDRAM reference clock
rst  in  1  asynchronous active-high reset
sdram_init_done  in  1  SDRAM core initialised; no requests are issued while low
wr_need  in  NUM_PORTS  write FIFO p holds at least one burst
rd_need  in  NUM_PORTS  read FIFO p has room for one burst
wr_length / rd_length  in  NUM_PORTS*LEN_W  per-channel burst length, packed, channel 0 in LSBs
wr_addr / wr_max_addr  in  NUM_PORTS*ADDR_W  per-channel write start address / end address (exclusive)
rd_addr / rd_max_addr  in  NUM_PORTS*ADDR_W  per-channel read start address / end address (exclusive)
wr_load / rd_load  in  NUM_PORTS  one-cycle pulse: reload the channel pointer from its start address and clear done
sdram_wr_req / sdram_rd_req  out  1  request to the SDRAM core
sdram_wr_ack / sdram_rd_ack  in  1  core ack; held high for the whole data burst
sdram_wraddr / sdram_rdaddr  out  ADDR_W  burst start address for the granted channel
sdwr_byte / sdrd_byte  out  LEN_W  burst length for the granted channel
wr_ack_ch / rd_ack_ch  out  NUM_PORTS  core ack steered to the granted channel only; drives that FIFO's read/write enable
wr_done / rd_done  out  NUM_PORTS  sticky; a one-shot channel has reached its max address

Behaviour:
- Reset: all outputs 0. Pointers are loaded from wr_addr/rd_addr. Done flags are cleared. Round-robin pointer is set to write channel 0. FSM enters IDLE.
- Request vector is 2*NUM_PORTS entries, ordered W0..Wn-1, R0..Rn-1. Entry k is eligible when its need bit is 1, its done bit is 0 and sdram_init_done is 1.
- FSM states:
  - IDLE: if any entry is eligible, pick the first eligible entry at or after the round-robin pointer (circular order). Register grant, address and length. Go to REQ.
  - REQ: assert sdram_wr_req or sdram_rd_req (registered, first cycle after IDLE). Drive sdram_*addr and sd*_byte from the latched values, held stable. Stay until the matching ack is 1.
  - BURST: deassert the request on the cycle after ack is seen high. wr_ack_ch[g] or rd_ack_ch[g] equals the core ack combinationally. Stay until ack falls to 0.
  - UPD: one cycle. Compute next = ptr + len (ADDR_W+1 bits, no overflow). If next >= max: a wrap channel reloads its start address; a one-shot channel keeps ptr and sets done. Otherwise ptr = next. Round-robin pointer moves to g+1 mod 2*NUM_PORTS. Go to IDLE.
- Minimum gap from IDLE decision to request is 1 cycle. Back-to-back bursts cost 2 idle cycles (UPD, IDLE).
- A load pulse on a channel that is not granted takes effect next cycle: ptr = start, done = 0.
- A load pulse on the granted channel during REQ or BURST sets a pending flag. UPD then applies the load instead of the increment/wrap and clears done. The pulse is never lost.
- A load and a need on the same cycle: load first; the channel remains eligible in the following IDLE.
- rst asserted mid-burst aborts immediately: request drops, all state resets. The SDRAM core is reset by the same source.
- A length of 0 is treated as ineligible; the channel is never granted.
- Only one of sdram_wr_req / sdram_rd_req is ever high at a time. Both are 0 while sdram_init_done is 0.

Decomposition:
- Shared package sdram_arb_pkg: FSM state enum (IDLE, REQ, BURST, UPD) and a function to unpack channel p from a packed bus.
- One sub-module sdram_rr_pick: combinational round-robin first-eligible selector (req vector plus pointer in, one-hot grant and index out). Reusable for other arbiters.

Test Plan:
- Init gating: sdram_init_done=0, wr_need=2'b11 for 100 cycles -> no request. Raise init -> sdram_wr_req for W0 at sdram_wraddr=0x000000, sdwr_byte=256.
- Round robin: all four needs high, lengths 256, acks of 256 cycles -> grant order W0,W1,R0,R1,W0. wr_ack_ch/rd_ack_ch one-hot during each burst.
- Wrap: W0 start=0x100, max=0x400, len=256 -> burst addresses 0x100, 0x200, 0x300, 0x100. wr_done[0] stays 0.
- One-shot: RD_WRAP[1]=0, R1 start=0, max=0x200, len=256 -> bursts at 0x000, 0x100, then rd_done[1]=1 and no further R1 requests. rd_load[1] pulse -> done cleared, next burst at 0x000.
- Load mid-burst: wr_load[0] pulse during W0 BURST at 0x200 -> next W0 burst at start address, not 0x300.
- Reset mid-burst: rst high during BURST -> all outputs 0 next cycle. After release, first grant is W0 at its start address.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and helpers for the SDRAM port arbiter
// Contents:
//   arb_state_t  arbiter FSM state (IDLE, REQ, BURST, UPD)
//   ARB_BUS_W    widest packed per-channel bus get_field accepts
//   ARB_FIELD_W  widest single field get_field returns
//   get_field    extract field idx of width w from a packed bus (field 0 in LSBs)
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_UPD   = 2'd3
  } arb_state_t;

  localparam int ARB_BUS_W   = 128;
  localparam int ARB_FIELD_W = 32;

  function automatic logic [ARB_FIELD_W-1:0] get_field(
    input logic [ARB_BUS_W-1:0] bus,
    input int                   idx,
    input int                   w
  );
    logic [ARB_BUS_W-1:0]   sh;
    logic [ARB_FIELD_W-1:0] m;
    sh = bus >> (idx * w);
    if (w >= ARB_FIELD_W) m = '1;
    else                  m = (ARB_FIELD_W'(1) << w) - ARB_FIELD_W'(1);
    return sh[ARB_FIELD_W-1:0] & m;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// rtl/sdram_rr_pick.sv - combinational round-robin first-eligible selector
// Ports:
//   i_req    N      request vector, one bit per entry
//   i_ptr    IDX_W  entry with highest priority this cycle
//   o_grant  N      one-hot grant (all zero when nothing requests)
//   o_idx    IDX_W  index of the granted entry
//   o_valid  1      at least one entry requests
module sdram_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the farthest offset down to offset 0 so the entry closest to
  // i_ptr (in circular order) is the last one written and therefore wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = (int'(i_ptr) + i) % N;
      if (i_req[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter of NUM_PORTS write and read channels onto one SDRAM core
// Ports:
//   i_clk_ref, i_rst                SDRAM reference clock, async active-high reset
//   i_sdram_init_done               core initialised; gates all requests
//   i_wr_need / i_rd_need           per-channel burst ready
//   i_wr_length / i_rd_length       per-channel burst length (packed, ch0 in LSBs)
//   i_wr_addr / i_wr_max_addr       per-channel write start / exclusive end address
//   i_rd_addr / i_rd_max_addr       per-channel read start / exclusive end address
//   i_wr_load / i_rd_load           pulse: reload pointer from start, clear done
//   o_sdram_wr_req / o_sdram_rd_req request to the core
//   i_sdram_wr_ack / i_sdram_rd_ack core ack, high for the whole burst
//   o_sdram_wraddr / o_sdram_rdaddr burst start address
//   o_sdwr_byte / o_sdrd_byte       burst length
//   o_wr_ack_ch / o_rd_ack_ch       ack steered to the granted channel
//   o_wr_done / o_rd_done           sticky: one-shot channel reached its end
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                   NUM_PORTS = 2,
  parameter int                   ADDR_W    = 22,
  parameter int                   LEN_W     = 9,
  parameter logic [NUM_PORTS-1:0] WR_WRAP   = '1,
  parameter logic [NUM_PORTS-1:0] RD_WRAP   = '1
) (
  input  logic                          i_clk_ref,
  input  logic                          i_rst,
  input  logic                          i_sdram_init_done,
  input  logic [NUM_PORTS-1:0]          i_wr_need,
  input  logic [NUM_PORTS-1:0]          i_rd_need,
  input  logic [NUM_PORTS*LEN_W-1:0]    i_wr_length,
  input  logic [NUM_PORTS*LEN_W-1:0]    i_rd_length,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_wr_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_wr_max_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_rd_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_rd_max_addr,
  input  logic [NUM_PORTS-1:0]          i_wr_load,
  input  logic [NUM_PORTS-1:0]          i_rd_load,
  output logic                          o_sdram_wr_req,
  output logic                          o_sdram_rd_req,
  input  logic                          i_sdram_wr_ack,
  input  logic                          i_sdram_rd_ack,
  output logic [ADDR_W-1:0]             o_sdram_wraddr,
  output logic [ADDR_W-1:0]             o_sdram_rdaddr,
  output logic [LEN_W-1:0]              o_sdwr_byte,
  output logic [LEN_W-1:0]              o_sdrd_byte,
  output logic [NUM_PORTS-1:0]          o_wr_ack_ch,
  output logic [NUM_PORTS-1:0]          o_rd_ack_ch,
  output logic [NUM_PORTS-1:0]          o_wr_done,
  output logic [NUM_PORTS-1:0]          o_rd_done
);

  // Entries 0..NUM_PORTS-1 are write channels, NUM_PORTS..NR-1 read channels.
  localparam int NR    = 2 * NUM_PORTS;
  localparam int IDX_W = $clog2(NR);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_rr;
  logic [IDX_W-1:0]    r_gidx;
  logic                r_is_rd;
  logic [ADDR_W-1:0]   r_ptr [NR];
  logic [NR-1:0]       r_done;
  logic [NR-1:0]       r_pend;
  logic                r_rst_ld;
  logic                r_wr_req;
  logic                r_rd_req;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [ADDR_W-1:0]   r_rdaddr;
  logic [LEN_W-1:0]    r_wrlen;
  logic [LEN_W-1:0]    r_rdlen;

  logic [ARB_BUS_W-1:0] w_wr_addr_x, w_wr_max_x, w_rd_addr_x, w_rd_max_x;
  logic [ARB_BUS_W-1:0] w_wr_len_x, w_rd_len_x;
  logic [ADDR_W-1:0]    w_start [NR];
  logic [ADDR_W-1:0]    w_max [NR];
  logic [ADDR_W-1:0]    w_eff_ptr [NR];
  logic [LEN_W-1:0]     w_len [NR];
  logic [NR-1:0]        w_need, w_load, w_wrap, w_req;
  logic [NR-1:0]        w_pick_grant;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [ADDR_W-1:0]    w_cur_addr;
  logic [LEN_W-1:0]     w_cur_len;
  logic [ADDR_W:0]      w_next;
  logic                 w_hit_max;
  logic                 w_ack;
  logic                 w_active;

  assign w_wr_addr_x = ARB_BUS_W'(i_wr_addr);
  assign w_wr_max_x  = ARB_BUS_W'(i_wr_max_addr);
  assign w_rd_addr_x = ARB_BUS_W'(i_rd_addr);
  assign w_rd_max_x  = ARB_BUS_W'(i_rd_max_addr);
  assign w_wr_len_x  = ARB_BUS_W'(i_wr_length);
  assign w_rd_len_x  = ARB_BUS_W'(i_rd_length);

  assign w_need = {i_rd_need, i_wr_need};
  assign w_load = {i_rd_load, i_wr_load};
  assign w_wrap = {RD_WRAP, WR_WRAP};

  // Right after reset the pointers still hold 0; until the first clock copies
  // the start addresses in, a grant must read the start address directly.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_start[p]             = ADDR_W'(get_field(w_wr_addr_x, p, ADDR_W));
      w_start[p + NUM_PORTS] = ADDR_W'(get_field(w_rd_addr_x, p, ADDR_W));
      w_max[p]               = ADDR_W'(get_field(w_wr_max_x, p, ADDR_W));
      w_max[p + NUM_PORTS]   = ADDR_W'(get_field(w_rd_max_x, p, ADDR_W));
      w_len[p]               = LEN_W'(get_field(w_wr_len_x, p, LEN_W));
      w_len[p + NUM_PORTS]   = LEN_W'(get_field(w_rd_len_x, p, LEN_W));
    end
    for (int k = 0; k < NR; k++) begin
      w_eff_ptr[k] = r_rst_ld ? w_start[k] : r_ptr[k];
    end
  end

  // A channel with a load pulse this cycle sits out one arbitration round so
  // it is granted from its freshly reloaded pointer, never the stale one.
  always_comb begin
    w_req = '0;
    for (int k = 0; k < NR; k++) begin
      w_req[k] = w_need[k] & ~r_done[k] & i_sdram_init_done &
                 (w_len[k] != '0) & ~w_load[k];
    end
  end

  sdram_rr_pick #(
    .N     (NR),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_cur_addr = r_is_rd ? r_rdaddr : r_wraddr;
  assign w_cur_len  = r_is_rd ? r_rdlen : r_wrlen;
  assign w_next     = {1'b0, w_cur_addr} + (ADDR_W + 1)'(w_cur_len);
  assign w_hit_max  = w_next >= {1'b0, w_max[r_gidx]};
  assign w_ack      = r_is_rd ? i_sdram_rd_ack : i_sdram_wr_ack;
  assign w_active   = (r_state == ST_REQ) || (r_state == ST_BURST);

  always_ff @(posedge i_clk_ref or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_rr     <= '0;
      r_gidx   <= '0;
      r_is_rd  <= 1'b0;
      r_done   <= '0;
      r_pend   <= '0;
      r_rst_ld <= 1'b1;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_wraddr <= '0;
      r_rdaddr <= '0;
      r_wrlen  <= '0;
      r_rdlen  <= '0;
      for (int k = 0; k < NR; k++) r_ptr[k] <= '0;
    end else begin
      r_rst_ld <= 1'b0;
      for (int k = 0; k < NR; k++) begin
        if (r_rst_ld) r_ptr[k] <= w_start[k];
        if (w_load[k]) begin
          // The granted channel's pointer is in use; defer its reload to UPD.
          if (r_state != ST_IDLE && IDX_W'(k) == r_gidx) begin
            r_pend[k] <= 1'b1;
          end else begin
            r_ptr[k]  <= w_start[k];
            r_done[k] <= 1'b0;
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gidx <= w_pick_idx;
            if (w_pick_idx >= IDX_W'(NUM_PORTS)) begin
              r_is_rd  <= 1'b1;
              r_rd_req <= 1'b1;
              r_rdaddr <= w_eff_ptr[w_pick_idx];
              r_rdlen  <= w_len[w_pick_idx];
            end else begin
              r_is_rd  <= 1'b0;
              r_wr_req <= 1'b1;
              r_wraddr <= w_eff_ptr[w_pick_idx];
              r_wrlen  <= w_len[w_pick_idx];
            end
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!w_ack) r_state <= ST_UPD;
        end
        ST_UPD: begin
          if (r_pend[r_gidx] || w_load[r_gidx]) begin
            r_ptr[r_gidx]  <= w_start[r_gidx];
            r_done[r_gidx] <= 1'b0;
            r_pend[r_gidx] <= 1'b0;
          end else if (w_hit_max) begin
            if (w_wrap[r_gidx]) r_ptr[r_gidx]  <= w_start[r_gidx];
            else                r_done[r_gidx] <= 1'b1;
          end else begin
            r_ptr[r_gidx] <= w_next[ADDR_W-1:0];
          end
          r_rr    <= (r_gidx == IDX_W'(NR - 1)) ? '0 : r_gidx + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sdram_wr_req = r_wr_req & i_sdram_init_done;
  assign o_sdram_rd_req = r_rd_req & i_sdram_init_done;
  assign o_sdram_wraddr = r_wraddr;
  assign o_sdram_rdaddr = r_rdaddr;
  assign o_sdwr_byte    = r_wrlen;
  assign o_sdrd_byte    = r_rdlen;
  assign o_wr_done      = r_done[NUM_PORTS-1:0];
  assign o_rd_done      = r_done[NR-1:NUM_PORTS];

  always_comb begin
    o_wr_ack_ch = '0;
    o_rd_ack_ch = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_wr_ack_ch[p] = w_active & ~r_is_rd & (r_gidx == IDX_W'(p)) & i_sdram_wr_ack;
      o_rd_ack_ch[p] = w_active & r_is_rd & (r_gidx == IDX_W'(p + NUM_PORTS)) & i_sdram_rd_ack;
    end
  end

endmodule
